// File: rtl/period_meter_if.sv
// period_meter_if: groups the measured input and the measurement results.
//   sig_in       : asynchronous signal under measurement (driven by master)
//   period       : in_clk cycles between the last two rising edges
//   high_time    : in_clk cycles from that period's rising edge to its falling edge
//   period_valid : one-cycle strobe when period/high_time update
//   timeout      : level, set when no rising edge arrives for TIMEOUT cycles
// The meter itself connects through the slave modport.
interface period_meter_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;

  modport master (
    output sig_in,
    input  period, high_time, period_valid, timeout
  );

  modport slave (
    input  sig_in,
    output period, high_time, period_valid, timeout
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous input in
// in_clk cycles; results update once per input period with a one-cycle strobe.
//   in_clk : system clock, all logic on its rising edge
//   rst_n  : synchronous active-low reset
//   pm     : period_meter_if slave (sig_in in; period, high_time,
//            period_valid, timeout out)
module period_meter #(
  parameter int               CNT_W   = 28,
  parameter logic [CNT_W-1:0] TIMEOUT = 28'd250000000
) (
  input  logic           in_clk,
  input  logic           rst_n,
  period_meter_if.slave  pm
);

  typedef enum logic [0:0] {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

  logic             r_s1, r_s2, r_s3;
  logic             w_rise, w_fall;
  logic [CNT_W-1:0] r_cnt, r_hold;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_period, w_period;
  logic [CNT_W-1:0] r_high, w_high;
  logic             r_valid, w_valid;
  logic             r_timeout, w_timeout;

  // s1/s2 resynchronise; s3 is only an edge-detect delay.
  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge in_clk) begin
    if (!rst_n) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_state   <= WAIT_FIRST;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_s1 <= pm.sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      // Counter restarts at 1 so its value on the next rise is the distance.
      if (w_rise)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != TIMEOUT)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_fall)
        r_hold <= r_cnt;
      r_state   <= w_state_nxt;
      r_period  <= w_period;
      r_high    <= w_high;
      r_valid   <= w_valid;
      r_timeout <= w_timeout;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_period    = r_period;
    w_high      = r_high;
    w_valid     = 1'b0;
    w_timeout   = r_timeout;
    case (r_state)
      WAIT_FIRST: begin
        // First rise only arms; there is no start point to measure from yet.
        if (w_rise)
          w_state_nxt = MEASURE;
      end
      MEASURE: begin
        // A rise on the saturation cycle takes priority over the timeout.
        if (w_rise) begin
          w_period  = r_cnt;
          w_high    = r_hold;
          w_valid   = 1'b1;
          w_timeout = 1'b0;
        end else if (r_cnt == TIMEOUT) begin
          w_timeout   = 1'b1;
          w_state_nxt = WAIT_FIRST;
        end
      end
      default: w_state_nxt = WAIT_FIRST;
    endcase
  end

  assign pm.period       = r_period;
  assign pm.high_time    = r_high;
  assign pm.period_valid = r_valid;
  assign pm.timeout      = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;
  localparam int               CNT_W = 28;
  localparam logic [CNT_W-1:0] TO    = 28'd100;
  localparam int               TO_I  = 100;
  localparam int               HMAX  = 65536;

  logic clk;
  logic rst_n;

  period_meter_if #(.CNT_W(CNT_W)) pm ();

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .in_clk (clk),
    .rst_n  (rst_n),
    .pm     (pm)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
  } ev_t;

  typedef struct {
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
    logic             to;
  } lvl_t;

  ev_t  evq[$];
  lvl_t lvq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_msg   = 0;

  // Reference model in terms of timestamps: every edge records the sampled
  // input; a rise/fall is recognised two edges after it was sampled, and the
  // count is simply the elapsed edges since the last recognised rise.
  bit               hist [0:HMAX-1];
  int               cyc        = 0;
  int               rst_edge   = 0;
  int               last_rise  = 0;
  bit               rose       = 0;
  bit               armed      = 0;
  int               hold_m     = 0;
  logic [CNT_W-1:0] m_per      = '0;
  logic [CNT_W-1:0] m_hi       = '0;
  logic             m_to       = 1'b0;

  function automatic bit h(input int e);
    if (e <= rst_edge || e < 0 || e >= HMAX) return 1'b0;
    return hist[e];
  endfunction

  always @(posedge clk) begin
    int  cnt;
    bit  rise, fall;
    ev_t ev;
    lvl_t l;
    cyc++;
    if (!rst_n) begin
      rst_edge = cyc;
      armed    = 0;
      rose     = 0;
      hold_m   = 0;
      m_per    = '0;
      m_hi     = '0;
      m_to     = 1'b0;
    end else begin
      if (cyc < HMAX) hist[cyc] = pm.sig_in;
      cnt  = rose ? (cyc - last_rise) : (cyc - rst_edge - 1);
      if (cnt > TO_I) cnt = TO_I;
      rise = h(cyc-2) && !h(cyc-3);
      fall = !h(cyc-2) && h(cyc-3);
      if (rise) begin
        if (armed) begin
          ev.cyc = cyc; ev.per = CNT_W'(cnt); ev.hi = CNT_W'(hold_m);
          evq.push_back(ev);
          m_per = CNT_W'(cnt);
          m_hi  = CNT_W'(hold_m);
          m_to  = 1'b0;
        end
        armed     = 1;
        rose      = 1;
        last_rise = cyc;
      end else if (armed && cnt == TO_I) begin
        m_to  = 1'b1;
        armed = 0;
      end
      if (fall) hold_m = cnt;
    end
    l.per = m_per; l.hi = m_hi; l.to = m_to;
    lvq.push_back(l);
  end

  task automatic fail_msg(input string s);
    n_fail++;
    if (n_msg < 40) $display("FAIL %s", s);
    n_msg++;
  endtask

  // Monitor: compares level outputs every cycle and pops the strobe queue
  // whenever the DUT presents period_valid.
  always @(negedge clk) begin
    lvl_t l;
    ev_t  e;
    if (lvq.size() > 0) begin
      l = lvq.pop_front();
      n_tests++;
      if (pm.period !== l.per || pm.high_time !== l.hi || pm.timeout !== l.to)
        fail_msg($sformatf("levels cyc=%0d got per=%0d hi=%0d to=%0b exp per=%0d hi=%0d to=%0b",
                 cyc, pm.period, pm.high_time, pm.timeout, l.per, l.hi, l.to));
    end
    if (pm.period_valid === 1'b1) begin
      n_tests++;
      if (evq.size() == 0)
        fail_msg($sformatf("strobe_unexpected cyc=%0d got per=%0d hi=%0d exp none",
                 cyc, pm.period, pm.high_time));
      else begin
        e = evq.pop_front();
        if (e.cyc != cyc || pm.period !== e.per || pm.high_time !== e.hi)
          fail_msg($sformatf("strobe cyc=%0d got per=%0d hi=%0d exp cyc=%0d per=%0d hi=%0d",
                   cyc, pm.period, pm.high_time, e.cyc, e.per, e.hi));
      end
    end else if (pm.period_valid !== 1'b0 && cyc > 0) begin
      n_tests++;
      fail_msg($sformatf("strobe_x cyc=%0d got %b exp 0/1", cyc, pm.period_valid));
    end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
      n_tests++;
      e = evq.pop_front();
      fail_msg($sformatf("strobe_missing cyc=%0d got none exp cyc=%0d per=%0d hi=%0d",
               cyc, e.cyc, e.per, e.hi));
    end
  end

  task automatic step(input bit v, input bit r);
    @(posedge clk);
    #1;
    pm.sig_in = v;
    rst_n     = r;
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      repeat (hi) step(1'b1, 1'b1);
      repeat (lo) step(1'b0, 1'b1);
    end
  endtask

  initial begin
    pm.sig_in = 1'b0;
    rst_n     = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1);

    // square 10/10
    wave(10, 10, 5);
    // asymmetric 3/7 then minimum 1/1
    wave(3, 7, 4);
    wave(1, 1, 8);
    // period 20, then silence long enough to time out, then restart
    wave(10, 10, 2);
    repeat (130) step(1'b0, 1'b1);
    wave(10, 10, 3);
    // period exactly TIMEOUT
    wave(50, 50, 3);
    // reset pulse inside the low phase of a 50-cycle period
    wave(25, 25, 2);
    step(1'b1, 1'b1);
    repeat (24) step(1'b1, 1'b1);
    repeat (10) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (14) step(1'b0, 1'b1);
    wave(25, 25, 3);
    // input high through reset, then period 16
    step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    repeat (7) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    wave(8, 8, 4);

    // randomized waveforms with occasional timeouts and resets
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)
        repeat (int'($urandom_range(95, 140))) step(1'b0, 1'b1);
      else if (r == 1)
        step(pm.sig_in, 1'b0);
      else
        wave(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)), 1);
    end

    repeat (6) step(1'b0, 1'b1);
    @(negedge clk);
    n_tests++;
    if (evq.size() != 0)
      fail_msg($sformatf("strobe_drain got %0d pending exp 0", evq.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
